// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings and lane helpers for the load/store controller
package mem_access_pkg;

    // Access width encodings carried on req_kind (2'b11 also decodes as byte)
    localparam logic [1:0] KIND_WORD = 2'b00;
    localparam logic [1:0] KIND_HALF = 2'b01;
    localparam logic [1:0] KIND_BYTE = 2'b10;

    // Controller FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Half accesses need an even address, word accesses a 4-byte aligned one
    function automatic logic is_misaligned(input logic [1:0] kind, input logic [1:0] lo);
        return ((kind == KIND_WORD) && (lo != 2'b00)) || ((kind == KIND_HALF) && lo[0]);
    endfunction

    // Byte-lane enables for an aligned access
    function automatic logic [3:0] lane_be(input logic [1:0] kind, input logic [1:0] lo);
        case (kind)
            KIND_WORD: return 4'b1111;
            KIND_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b0001 << lo;
        endcase
    endfunction

    // Replicate right-aligned store data across all lanes so the enables pick the bytes
    function automatic logic [31:0] lane_wdata(input logic [1:0] kind, input logic [31:0] wdata);
        case (kind)
            KIND_WORD: return wdata;
            KIND_HALF: return {wdata[15:0], wdata[15:0]};
            default:   return {4{wdata[7:0]}};
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_ext.sv
// rtl/lsu_lane_ext.sv - load lane shift and sign/zero extension (combinational)
module lsu_lane_ext
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  kind,
    input  logic        sext,
    output logic [31:0] data
);

    logic [31:0] w_shift;

    // Bring the addressed lane down to bit 0; aligned words shift by zero
    assign w_shift = rdata >> {addr_lo, 3'b000};

    // Extend from the top bit of the selected width
    always_comb begin
        data = w_shift;
        case (kind)
            KIND_WORD: data = w_shift;
            KIND_HALF: data = {{16{sext & w_shift[15]}}, w_shift[15:0]};
            default:   data = {{24{sext & w_shift[7]}}, w_shift[7:0]};
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store access controller (optional ack watchdog: LSU_TIMEOUT_EN)
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_kind,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    logic [1:0]  r_state;
    logic        r_we;
    logic [1:0]  r_kind;
    logic        r_sext;
    logic [1:0]  r_addr_lo;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] w_ext;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [CW-1:0] r_wdog;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    lsu_lane_ext u_lane_ext (
        .rdata   (mem_rdata),
        .addr_lo (r_addr_lo),
        .kind    (r_kind),
        .sext    (r_sext),
        .data    (w_ext)
    );

    // Sequence each request through IDLE -> ACCESS -> RESP, or straight to RESP when misaligned
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_kind      <= KIND_WORD;
            r_sext      <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_be    <= 4'h0;
            r_mem_wdata <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_wdog      <= '0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we      <= req_we;
                        r_kind    <= req_kind;
                        r_sext    <= req_sext;
                        r_addr_lo <= req_addr[1:0];
                        if (is_misaligned(req_kind, req_addr[1:0])) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'h0;
                        end else begin
                            r_state     <= ST_ACCESS;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= req_we;
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_mem_be    <= lane_be(req_kind, req_addr[1:0]);
                            r_mem_wdata <= lane_wdata(req_kind, req_wdata);
`ifdef LSU_TIMEOUT_EN
                            r_wdog      <= '0;
`endif
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        r_state     <= ST_RESP;
                        r_mem_req   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_we ? 32'h0 : w_ext;
`ifdef LSU_TIMEOUT_EN
                    end else if (r_wdog == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_state     <= ST_RESP;
                        r_mem_req   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= 32'h0;
                        r_wdog      <= r_wdog + 1'b1;
                    end else begin
                        r_wdog      <= r_wdog + 1'b1;
`endif
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl (timeout case with LSU_TIMEOUT_EN)
module tb_mem_access_ctrl;

`ifdef LSU_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } memx_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_kind = 2'b00;
    logic        req_sext = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int total = 0;
    int bad = 0;

    rsp_t  exp_rsp[$];
    memx_t exp_mem[$];
    memx_t cur_mem;
    logic [31:0] ref_mem [8];
    logic [31:0] dut_mem [8];

    int  ack_mode = 0;     // 0 auto, 1 withheld, 2 forced high
    int  max_dly = 3;
    bit  pending = 0;
    int  dly = 0;
    bit  mem_req_prev = 0;
    int  mem_req_rises = 0;
    int  mem_req_cycles = 0;
    int  rsp_seen = 0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_kind(req_kind), .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory responder: random ack delay, memory contents kept in dut_mem
    always @(negedge clk) begin
        if (rst) begin
            pending = 0;
            if (ack_mode != 2) mem_ack = 1'b0;
        end
        if (ack_mode == 2) begin
            mem_ack = 1'b1;
            mem_rdata = $urandom;
        end else if (ack_mode == 1) begin
            mem_ack = 1'b0;
            pending = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req && !rst) begin
            if (!pending) begin
                pending = 1;
                dly = $urandom_range(0, max_dly);
            end
            if (dly == 0) begin
                pending = 0;
                mem_ack = 1'b1;
                mem_rdata = dut_mem[mem_addr[4:2]];
                if (mem_we)
                    for (int i = 0; i < 4; i++)
                        if (mem_be[i]) dut_mem[mem_addr[4:2]][8*i +: 8] = mem_wdata[8*i +: 8];
            end else begin
                dly--;
            end
        end
    end

    // Monitor: memory-side transactions and responses against the scoreboard
    always @(negedge clk) begin
        if (mem_req) begin
            mem_req_cycles++;
            if (!mem_req_prev) begin
                mem_req_rises++;
                chk("mem_q_nonempty", 32'(exp_mem.size() != 0), 32'd1);
                if (exp_mem.size() != 0) cur_mem = exp_mem.pop_front();
            end
            chk("mem_addr", mem_addr, cur_mem.addr);
            chk("mem_we", 32'(mem_we), 32'(cur_mem.we));
            chk("mem_be", 32'(mem_be), 32'(cur_mem.be));
            if (cur_mem.we) chk("mem_wdata", mem_wdata, cur_mem.wdata);
        end
        mem_req_prev = mem_req;
        if (rsp_valid) begin
            rsp_seen++;
            chk("rsp_q_nonempty", 32'(exp_rsp.size() != 0), 32'd1);
            if (exp_rsp.size() != 0) begin
                rsp_t e;
                e = exp_rsp.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    // Issue one request from a negedge; reference expectations come from ref_mem
    task automatic issue(input logic we, input logic [1:0] kind, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit wait_done,
                         input bit has_ovr, input logic [31:0] ovr_rdata, input logic ovr_err,
                         output int lat);
        int n;
        int nb;
        int a;
        int idx;
        logic mis;
        rsp_t r;
        memx_t m;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_wait", 32'(req_ready), 32'd1);
        nb  = (kind == 2'b00) ? 4 : (kind == 2'b01) ? 2 : 1;
        a   = int'(addr[1:0]);
        idx = int'(addr[4:2]);
        mis = (a % nb) != 0;
        r.rdata = 32'h0;
        r.err   = mis;
        if (!mis) begin
            m.addr = {addr[31:2], 2'b00};
            m.we = we;
            m.be = 4'h0;
            m.wdata = 32'h0;
            for (int i = 0; i < nb; i++) m.be[a + i] = 1'b1;
            for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = wdata[8*(i % nb) +: 8];
            exp_mem.push_back(m);
            if (we) begin
                if (wait_done)
                    for (int i = 0; i < nb; i++) ref_mem[idx][8*(a+i) +: 8] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) r.rdata[8*i +: 8] = ref_mem[idx][8*(a+i) +: 8];
                if (sext && nb < 4 && r.rdata[8*nb-1])
                    for (int i = nb; i < 4; i++) r.rdata[8*i +: 8] = 8'hFF;
            end
        end
        if (has_ovr) begin
            r.rdata = ovr_rdata;
            r.err = ovr_err;
        end
        if (wait_done) exp_rsp.push_back(r);
        req_valid = 1'b1;
        req_we = we;
        req_kind = kind;
        req_sext = sext;
        req_addr = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        if (wait_done) begin
            while (!rsp_valid && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            if (!rsp_valid) chk("rsp_wait", 32'(rsp_valid), 32'd1);
        end
    endtask

    initial begin
        int lat;
        int rises0;
        int seen0;
        logic [1:0]  k;
        logic [31:0] ad;
        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = $urandom;
            dut_mem[i] = ref_mem[i];
        end
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_mem_be", 32'(mem_be), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // LB 0x1003 sext, minimum latency
        max_dly = 0;
        ref_mem[0] = 32'h80FF_FF7F;
        dut_mem[0] = 32'h80FF_FF7F;
        issue(1'b0, 2'b10, 1'b1, 32'h0000_1003, 32'h0, 1, 1, 32'hFFFF_FF80, 1'b0, lat);
        chk("lb_latency", 32'(lat), 32'd2);

        // LHU 0x2002
        ref_mem[0] = 32'hBEEF_1234;
        dut_mem[0] = 32'hBEEF_1234;
        issue(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 1, 1, 32'h0000_BEEF, 1'b0, lat);

        // SB 0x11 (lane/address expectations derived in issue)
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0011, 32'h0000_00A5, 1, 1, 32'h0, 1'b0, lat);

        // LW 0x6 misaligned: no memory access, response one cycle after accept
        rises0 = mem_req_rises;
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0006, 32'h0, 1, 1, 32'h0, 1'b1, lat);
        chk("mis_latency", 32'(lat), 32'd1);
        chk("mis_no_mem_req", 32'(mem_req_rises), 32'(rises0));

        // SW with ack withheld, then reset mid-access; late ack ignored
        ack_mode = 1;
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0008, 32'h1234_5678, 0, 0, 32'h0, 1'b0, lat);
        repeat (4) @(negedge clk);
        chk("sw_hold_mem_req", 32'(mem_req), 32'd1);
        seen0 = rsp_seen;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        rst = 1'b0;
        ack_mode = 2;
        repeat (3) @(negedge clk);
        ack_mode = 0;
        @(negedge clk);
        chk("late_ack_no_rsp", 32'(rsp_seen), 32'(seen0));
        for (int i = 0; i < 8; i++) dut_mem[i] = ref_mem[i];

`ifdef LSU_TIMEOUT_EN
        // Watchdog: no ack, mem_req held for TO cycles then error response
        ack_mode = 1;
        mem_req_cycles = 0;
        issue(1'b0, 2'b00, 1'b0, 32'h0000_000C, 32'h0, 1, 1, 32'h0, 1'b1, lat);
        chk("to_mem_req_cycles", 32'(mem_req_cycles), 32'(TO));
        chk("to_latency", 32'(lat), 32'(TO + 1));
        ack_mode = 0;
`endif

        // Randomized traffic against the reference memory
        max_dly = 3;
        for (int t = 0; t < 60; t++) begin
            k  = 2'($urandom_range(0, 3));
            ad = {27'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) != 0) begin
                if (k == 2'b00) ad[1:0] = 2'b00;
                else if (k == 2'b01) ad[0] = 1'b0;
            end
            issue(1'($urandom_range(0, 1)), k, 1'($urandom_range(0, 1)), ad, $urandom,
                  1, 0, 32'h0, 1'b0, lat);
        end
        repeat (3) @(negedge clk);
        chk("rsp_q_drained", 32'(exp_rsp.size()), 32'd0);
        chk("mem_q_drained", 32'(exp_mem.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the memory-ack watchdog limit in cycles (used only with LSU_TIMEOUT_EN).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 req_valid  input  1  SHALL indicate a load/store request from the pipeline.
REQ-005 req_ready  output  1  SHALL indicate the controller accepts a request this cycle.
REQ-006 req_we  input  1  SHALL select store (1) or load (0).
REQ-007 req_kind  input  2  SHALL select access width: 00 word, 01 half, 10 and 11 byte.
REQ-008 req_sext  input  1  SHALL select sign (1) or zero (0) extension for sub-word loads.
REQ-009 req_addr  input  32  SHALL be the byte address.
REQ-010 req_wdata  input  32  SHALL be the store data (right-aligned).
REQ-011 mem_req, mem_we  output  1 each  SHALL request a memory access and mark it a write.
REQ-012 mem_addr  output  32  SHALL be the word-aligned address, req_addr with bits [1:0] forced to 0.
REQ-013 mem_be  output  4  SHALL be the byte-lane enables.
REQ-014 mem_wdata  output  32  SHALL be the lane-replicated store data.
REQ-015 mem_ack  input  1  SHALL complete the outstanding access.
REQ-016 mem_rdata  input  32  SHALL be the read word, valid when mem_ack=1.
REQ-017 rsp_valid  output  1  SHALL pulse for one cycle when an access completes.
REQ-018 rsp_rdata  output  32  SHALL be the extended load result.
REQ-019 rsp_err  output  1  SHALL flag a misaligned access or timeout, qualified by rsp_valid.
REQ-020 busy  output  1  SHALL be high whenever state is not IDLE (pipeline stall).

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 IDLE with req_valid=1 SHALL latch all req_* inputs; on misalignment (half with addr[0]=1, word with addr[1:0]!=0) the FSM SHALL go to RESP with err=1 and SHALL NOT assert mem_req.
REQ-023 An aligned request SHALL go to ACCESS; mem_req SHALL hold high with stable mem_addr/mem_we/mem_be/mem_wdata until mem_ack=1 is sampled, then the FSM SHALL go to RESP.
REQ-024 mem_ack outside ACCESS SHALL be ignored.
REQ-025 Minimum latency: accept at edge N, mem_ack at N+1, rsp_valid high during cycle N+2.
REQ-026 RESP SHALL assert rsp_valid for exactly one cycle and return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-027 mem_be SHALL be 1111 for word, 0011/1100 for half at addr[1]=0/1, and 0001 shifted left by addr[1:0] for byte.
REQ-028 mem_wdata SHALL be wdata for word, {wdata[15:0],wdata[15:0]} for half, and wdata[7:0] replicated four times for byte.
REQ-029 Loads SHALL right-shift mem_rdata by 8*addr[1:0], then sign- or zero-extend bit 15 (half) or bit 7 (byte) per req_sext; word loads SHALL pass unchanged; the result SHALL be registered on mem_ack.
REQ-030 For stores, rsp_rdata SHALL be 0.

Reset
REQ-031 rst=1 SHALL force state IDLE, and mem_req, mem_we, rsp_valid, rsp_err and busy to 0, and mem_be, rsp_rdata and the watchdog counter to 0 at the next edge, including mid-ACCESS; a late mem_ack is then ignored.

Configuration
REQ-032 With macro LSU_TIMEOUT_EN defined, a counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack; on reaching TIMEOUT_CYCLES it SHALL drop mem_req and go to RESP with err=1 and rsp_rdata=0.
REQ-033 Without LSU_TIMEOUT_EN, ACCESS SHALL wait indefinitely and no counter logic SHALL exist.

Structure
REQ-034 Package mem_access_pkg SHALL hold the kind encodings (KIND_WORD, KIND_HALF, KIND_BYTE) and the FSM state encoding.
REQ-035 Lane shift and extension SHALL be sub-module lsu_lane_ext (combinational; rdata, addr[1:0], kind, sext in; data out).

Verification
REQ-036 LB at addr 0x1003, sext=1, rdata 0x80FF_FF7F, ack next cycle -> rsp_rdata 0xFFFF_FF80, err=0, rsp_valid two cycles after accept.
REQ-037 LHU at addr 0x2002, rdata 0xBEEF_1234 -> rsp_rdata 0x0000_BEEF.
REQ-038 SB at addr 0x11, wdata 0x0000_00A5 -> mem_be 0010, mem_wdata 0xA5A5_A5A5, mem_addr 0x10.
REQ-039 LW at addr 0x6 -> no mem_req, rsp_valid with rsp_err=1 one cycle after accept.
REQ-040 SW with ack withheld 5 cycles, then rst=1 -> mem_req=0 and busy=0 after the edge, ack raised afterwards produces no rsp_valid.
REQ-041 With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 ACCESS cycles, rsp_err=1.
